// File: rtl/frame_aligner.sv
// frame_aligner: recovers the 40-bit frame boundary from raw deserializer
// words by sliding a 40-bit window across the last two words. It looks for
// filler/header identifiers, verifies the candidate offset, then streams
// aligned frames while locked. The optional lock-loss statistics counter is
// enabled by defining FRAME_ALIGNER_STATS_EN; otherwise lockLossCount reads 0.
module frame_aligner #(
  parameter int LOCK_COUNT    = 8,
  parameter int MISS_LIMIT    = 4,
  parameter int UNLOCK_WINDOW = 512
) (
  input  logic        clk40,
  input  logic        reset,
  input  logic        rawValid,
  input  logic [39:0] rawIn,
  output logic        dataValid,
  output logic [39:0] dout,
  output logic        locked,
  output logic [5:0]  bitOffset,
  output logic [15:0] lockLossCount
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } alignStateT;

  // Counter thresholds expressed as "last value before the event" so the
  // comparisons stay within the counter widths.
  localparam logic [7:0]  MATCH_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0]  MISS_LAST  = 8'(MISS_LIMIT);
  localparam logic [9:0]  SINCE_LAST = 10'(UNLOCK_WINDOW - 1);
  localparam logic [17:0] FILLER_ID  = {16'h3C5C, 2'b10};
  localparam logic [17:0] HEADER_ID  = {16'h3C5C, 2'b00};
  localparam logic [5:0]  OFFSET_MAX = 6'd39;

  alignStateT  stateReg, stateNext;
  logic [39:0] prevWordReg, prevWordNext;
  logic [5:0]  bitOffsetReg, bitOffsetNext;
  logic [7:0]  matchCntReg, matchCntNext;
  logic [7:0]  missCntReg, missCntNext;
  logic [9:0]  sinceIdCntReg, sinceIdCntNext;
  logic [39:0] doutReg, doutNext;
  logic        dataValidReg, dataValidNext;
  logic        lockedReg;

  logic [5:0]  offsetAdvanced;
  logic [78:0] stream;
  logic [39:0] candidate [40];
  logic [39:0] window;
  logic        idMatch;

  // The window for offset k starts k bits into the previous word. The last
  // bit of rawIn can never be the start of a window, so it is left out.
  assign stream = {prevWordReg, rawIn[39:1]};

  generate
    for (genvar gi = 0; gi < 40; gi++) begin : gCandidate
      assign candidate[gi] = stream[78-gi -: 40];
    end
  endgenerate

  assign window  = candidate[bitOffsetReg];
  assign idMatch = (window[39:22] == FILLER_ID) || (window[39:22] == HEADER_ID);

  assign offsetAdvanced = (bitOffsetReg == OFFSET_MAX) ? 6'd0 : bitOffsetReg + 6'd1;

  // Next-state and next-output logic; nothing moves unless rawValid is high.
  always_comb begin
    stateNext      = stateReg;
    prevWordNext   = prevWordReg;
    bitOffsetNext  = bitOffsetReg;
    matchCntNext   = matchCntReg;
    missCntNext    = missCntReg;
    sinceIdCntNext = sinceIdCntReg;
    doutNext       = doutReg;
    dataValidNext  = 1'b0;

    if (rawValid) begin
      prevWordNext = rawIn;

      // A word seen while already locked is emitted, including the one that
      // ends the lock; the word that completes verification is not.
      if (stateReg == LOCKED) begin
        doutNext      = window;
        dataValidNext = 1'b1;
      end

      case (stateReg)
        SEARCH: begin
          if (idMatch) begin
            stateNext    = VERIFY;
            matchCntNext = 8'd1;
            missCntNext  = 8'd0;
          end else begin
            bitOffsetNext = offsetAdvanced;
          end
        end

        VERIFY: begin
          if (idMatch) begin
            if (matchCntReg == MATCH_LAST) begin
              stateNext      = LOCKED;
              sinceIdCntNext = 10'd0;
              matchCntNext   = 8'd0;
              missCntNext    = 8'd0;
            end else begin
              matchCntNext = matchCntReg + 8'd1;
            end
          end else begin
            if (missCntReg >= MISS_LAST) begin
              stateNext     = SEARCH;
              bitOffsetNext = offsetAdvanced;
              matchCntNext  = 8'd0;
              missCntNext   = 8'd0;
            end else begin
              missCntNext = missCntReg + 8'd1;
            end
          end
        end

        LOCKED: begin
          if (idMatch) begin
            sinceIdCntNext = 10'd0;
          end else if (sinceIdCntReg == SINCE_LAST) begin
            // Keep the offset: a brief outage usually recovers at the same phase.
            stateNext      = SEARCH;
            sinceIdCntNext = 10'd0;
          end else begin
            sinceIdCntNext = sinceIdCntReg + 10'd1;
          end
        end

        default: begin
          stateNext     = SEARCH;
          bitOffsetNext = 6'd0;
          matchCntNext  = 8'd0;
          missCntNext   = 8'd0;
        end
      endcase
    end
  end

  // State and output registers; reset discards the word presented with it.
  always_ff @(posedge clk40) begin
    if (reset) begin
      stateReg      <= SEARCH;
      prevWordReg   <= '0;
      bitOffsetReg  <= '0;
      matchCntReg   <= '0;
      missCntReg    <= '0;
      sinceIdCntReg <= '0;
      doutReg       <= '0;
      dataValidReg  <= 1'b0;
      lockedReg     <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      prevWordReg   <= prevWordNext;
      bitOffsetReg  <= bitOffsetNext;
      matchCntReg   <= matchCntNext;
      missCntReg    <= missCntNext;
      sinceIdCntReg <= sinceIdCntNext;
      doutReg       <= doutNext;
      dataValidReg  <= dataValidNext;
      lockedReg     <= (stateNext == LOCKED);
    end
  end

  assign dataValid = dataValidReg;
  assign dout      = doutReg;
  assign locked    = lockedReg;
  assign bitOffset = bitOffsetReg;

`ifdef FRAME_ALIGNER_STATS_EN
  logic [15:0] lockLossCountReg;
  logic        lockLossEvent;

  assign lockLossEvent = rawValid && (stateReg == LOCKED) && (stateNext == SEARCH);

  // Count lock-loss events, saturating so a long soak never wraps back to zero.
  always_ff @(posedge clk40) begin
    if (reset) begin
      lockLossCountReg <= '0;
    end else if (lockLossEvent && (lockLossCountReg != 16'hFFFF)) begin
      lockLossCountReg <= lockLossCountReg + 16'd1;
    end
  end

  assign lockLossCount = lockLossCountReg;
`else
  assign lockLossCount = 16'd0;
`endif

endmodule

// File: tb/tb_frame_aligner.sv
// tb_frame_aligner: directed stimulus for frame_aligner. A behavioural model
// computes the expected outputs from the alignment rules and a negedge
// process compares every cycle; literal expectations pin key points.
module tb_frame_aligner;

  localparam logic [39:0] FILLER = {16'h3C5C, 2'b10, 22'd0};  // 40'h3C5C800000

  logic        clk40 = 1'b0;
  logic        reset;
  logic        rawValid;
  logic [39:0] rawIn;
  logic        dataValid;
  logic [39:0] dout;
  logic        locked;
  logic [5:0]  bitOffset;
  logic [15:0] lockLossCount;

  frame_aligner dut (
    .clk40        (clk40),
    .reset        (reset),
    .rawValid     (rawValid),
    .rawIn        (rawIn),
    .dataValid    (dataValid),
    .dout         (dout),
    .locked       (locked),
    .bitOffset    (bitOffset),
    .lockLossCount(lockLossCount)
  );

  always #5 clk40 = ~clk40;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  // Model state: mode 0 = searching, 1 = verifying, 2 = locked.
  int          mMode, mOff, mMatch, mMiss, mSince, mLoss;
  logic [39:0] mPrev;
  bit          eValid, eLocked;
  logic [39:0] eDout;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] rotr(input logic [39:0] x, input int s);
    return (x >> s) | (x << (40 - s));
  endfunction

  // Frame n of the stall stream: frame 0 is the filler, later ones are
  // headers carrying n so that loss or duplication is visible.
  function automatic logic [39:0] frameN(input int n);
    logic [21:0] tag;
    tag = 22'(n);
    if (n == 0) return FILLER;
    return {16'h3C5C, 2'b00, tag};
  endfunction

  // Raw word n of that stream delivered with the frame boundary 13 bits in.
  function automatic logic [39:0] rawN(input int n);
    logic [39:0] a, b;
    a = frameN(n - 1);
    b = frameN(n);
    return {a[12:0], b[39:13]};
  endfunction

  task automatic modelStep(input bit rst, input bit v, input logic [39:0] w);
    logic [79:0] joined;
    logic [39:0] win;
    bit          hit;
    if (rst) begin
      mMode = 0; mOff = 0; mMatch = 0; mMiss = 0; mSince = 0; mLoss = 0;
      mPrev = '0; eValid = 1'b0; eLocked = 1'b0; eDout = '0;
    end else if (!v) begin
      eValid = 1'b0;
    end else begin
      joined = {mPrev, w} << mOff;
      win    = joined[79:40];
      hit    = (win[39:22] == {16'h3C5C, 2'b10}) || (win[39:22] == {16'h3C5C, 2'b00});
      eValid = (mMode == 2);
      if (eValid) eDout = win;
      if (mMode == 0) begin
        if (hit) begin mMode = 1; mMatch = 1; mMiss = 0; end
        else mOff = (mOff + 1) % 40;
      end else if (mMode == 1) begin
        if (hit) begin
          mMatch++;
          if (mMatch == 8) begin mMode = 2; mSince = 0; end
        end else begin
          mMiss++;
          if (mMiss > 4) begin mMode = 0; mOff = (mOff + 1) % 40; mMatch = 0; mMiss = 0; end
        end
      end else begin
        if (hit) mSince = 0;
        else begin
          mSince++;
          if (mSince == 512) begin
            mMode = 0;
`ifdef FRAME_ALIGNER_STATS_EN
            if (mLoss < 65535) mLoss++;
`endif
          end
        end
      end
      eLocked = (mMode == 2);
      mPrev   = w;
    end
  endtask

  task automatic drive(input bit rst, input bit v, input logic [39:0] w);
    @(negedge clk40);
    reset    = rst;
    rawValid = v;
    rawIn    = w;
    @(posedge clk40);
    modelStep(rst, v, w);
    #1;
  endtask

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk40) begin
    if (cmpEn) begin
      check("cyc_dataValid", 40'(dataValid), 40'(eValid));
      check("cyc_locked", 40'(locked), 40'(eLocked));
      check("cyc_bitOffset", 40'(bitOffset), 40'(mOff));
      check("cyc_lockLossCount", 40'(lockLossCount), 40'(mLoss));
      if (eValid) check("cyc_dout", dout, eDout);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [39:0] w13, w20, dWord;
    w13   = rotr(FILLER, 13);
    w20   = rotr(FILLER, 20);
    dWord = 40'hA5A5A5A5A5;
    reset = 1'b1; rawValid = 1'b0; rawIn = '0;

    // Reset state
    drive(1, 0, '0);
    cmpEn = 1'b1;
    drive(1, 1, FILLER);
    check("rst_dataValid", 40'(dataValid), 40'd0);
    check("rst_dout", dout, 40'd0);
    check("rst_locked", 40'(locked), 40'd0);
    check("rst_bitOffset", 40'(bitOffset), 40'd0);
    check("rst_lockLossCount", 40'(lockLossCount), 40'd0);

    // Offset 0: word 1 sees the cleared previous word, the search wraps
    // after 40 words, word 41 matches and word 48 completes verification.
    for (int i = 1; i <= 48; i++) begin
      drive(0, 1, FILLER);
      if (i == 47) check("off0_locked_w47", 40'(locked), 40'd0);
    end
    check("off0_locked_w48", 40'(locked), 40'd1);
    check("off0_bitOffset", 40'(bitOffset), 40'd0);
    check("off0_entry_not_output", 40'(dataValid), 40'd0);
    drive(0, 1, FILLER);
    check("off0_dataValid", 40'(dataValid), 40'd1);
    check("off0_dout", dout, FILLER);

    // Rotated by 13: match on word 14, lock on word 21, output from word 22.
    drive(1, 0, '0);
    for (int i = 1; i <= 21; i++) begin
      drive(0, 1, w13);
      if (i == 20) check("rot13_locked_w20", 40'(locked), 40'd0);
    end
    check("rot13_locked_w21", 40'(locked), 40'd1);
    check("rot13_bitOffset", 40'(bitOffset), 40'd13);
    drive(0, 1, w13);
    check("rot13_dataValid", 40'(dataValid), 40'd1);
    check("rot13_dout", dout, FILLER);

    // Stall transparency: each valid word emits the previous frame exactly once.
    for (int n = 1; n <= 6; n++) begin
      drive(0, 1, rawN(n));
      check("stall_dv_on", 40'(dataValid), 40'd1);
      check("stall_dout", dout, frameN(n - 1));
      drive(0, 0, 40'hDEADBEEF55);
      check("stall_dv_off", 40'(dataValid), 40'd0);
      check("stall_dout_hold", dout, frameN(n - 1));
      check("stall_locked_hold", 40'(locked), 40'd1);
      check("stall_offset_hold", 40'(bitOffset), 40'd13);
    end

    // Reset while verifying with five matches counted.
    drive(1, 0, '0);
    for (int i = 1; i <= 18; i++) drive(0, 1, w13);
    check("rstv_pre_locked", 40'(locked), 40'd0);
    check("rstv_pre_offset", 40'(bitOffset), 40'd13);
    drive(1, 1, w13);
    check("rstv_locked", 40'(locked), 40'd0);
    check("rstv_bitOffset", 40'(bitOffset), 40'd0);
    check("rstv_dataValid", 40'(dataValid), 40'd0);
    for (int i = 1; i <= 21; i++) drive(0, 1, w13);
    check("rstv_relock", 40'(locked), 40'd1);

    // False match at offset 5 rejected after five misses, true lock at 20.
    drive(1, 0, '0);
    for (int i = 1; i <= 4; i++) drive(0, 1, '0);
    drive(0, 1, FILLER >> 5);
    drive(0, 1, '0);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 40'hFF_FFFF_FFFF);
      if (i == 4) check("false_hold_offset5", 40'(bitOffset), 40'd5);
    end
    check("false_rejected_offset6", 40'(bitOffset), 40'd6);
    for (int i = 1; i <= 22; i++) begin
      drive(0, 1, w20);
      if (i == 21) check("false_locked_pre", 40'(locked), 40'd0);
    end
    check("false_final_locked", 40'(locked), 40'd1);
    check("false_final_offset", 40'(bitOffset), 40'd20);

    // Lock loss. The first data word still completes the last filler's
    // window, so the 512th identifier-free window arrives on data word 513.
    drive(0, 1, w20);
    drive(0, 1, w20);
    for (int i = 1; i <= 513; i++) begin
      drive(0, 1, dWord);
      if (i == 512) check("loss_locked_w512", 40'(locked), 40'd1);
    end
    check("loss_locked_w513", 40'(locked), 40'd0);
    check("loss_bitOffset", 40'(bitOffset), 40'd20);
    check("loss_exit_word_output", 40'(dataValid), 40'd1);
    check("loss_exit_dout", dout, 40'h5A5A5A5A5A);
`ifdef FRAME_ALIGNER_STATS_EN
    check("loss_count", 40'(lockLossCount), 40'd1);
`else
    check("loss_count", 40'(lockLossCount), 40'd0);
`endif
    drive(0, 1, dWord);
    check("loss_after_dv", 40'(dataValid), 40'd0);

    @(negedge clk40);
    cmpEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
